// File: rtl/obi_pkg.sv
// Shared OBI bus types and the responder state encoding.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_e;

endpackage

// File: rtl/sram_be_1p.sv
// Single-port byte-writable array with a registered read port.
// Contents and read register are intentionally unreset.
module sram_be_1p #(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned AW        = $clog2(NUM_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[k]) begin
            mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
          end
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/obi_sram_resp.sv
// OBI responder in front of a byte-write SRAM: programmable grant wait,
// one-cycle response latency, out-of-range accesses answered with an error word.
module obi_sram_resp
  import obi_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hF0010000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  req_i,
  output obi_resp_t resp_o,
  output logic      err_o
);

  localparam logic [31:0] ERR_DATA  = 32'hBADCAB1E;
  localparam int unsigned AW        = $clog2(NUM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(NUM_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_CYCLES);

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q;
  logic        gnt;
  logic        in_range;
  logic        err_q;
  logic        wr_q;
  logic [31:0] offset;
  logic [31:0] sram_rdata;

  // Subtracting first keeps the upper bound check free of 32-bit overflow.
  assign offset   = req_i.addr - BASE_ADDR;
  assign in_range = (req_i.addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign gnt      = req_i.req && !rst_i && (cnt_q == WAIT_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (req_i.req && !gnt) begin
      cnt_q <= cnt_q + 4'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        err_q <= !in_range;
        wr_q  <= req_i.we;
      end
    end
  end

  // Write responses return zero; errors override whatever the array holds.
  always_comb begin
    state_d     = IDLE;
    resp_o      = '0;
    err_o       = 1'b0;
    if (gnt) begin
      state_d = RESP;
    end
    resp_o.gnt = gnt;
    if (state_q == RESP) begin
      resp_o.rvalid = 1'b1;
      err_o         = err_q;
      if (err_q) begin
        resp_o.rdata = ERR_DATA;
      end else if (!wr_q) begin
        resp_o.rdata = sram_rdata;
      end
    end
  end

  sram_be_1p #(
    .NUM_WORDS(NUM_WORDS),
    .AW       (AW)
  ) u_sram (
    .clk_i  (clk_i),
    .en_i   (gnt && in_range),
    .we_i   (req_i.we),
    .addr_i (offset[AW+1:2]),
    .be_i   (req_i.be),
    .wdata_i(req_i.wdata),
    .rdata_o(sram_rdata)
  );

endmodule

// File: tb/tb_obi_sram_resp.sv
// Self-checking bench for obi_sram_resp: one zero-wait and one three-wait instance,
// directed tables and sequences plus random traffic against a transaction-level model.
module tb_obi_sram_resp;
  import obi_pkg::*;

  localparam logic [31:0] BASE     = 32'hF0010000;
  localparam logic [31:0] ERR_WORD = 32'hBADCAB1E;
  localparam int          WAITS [2] = '{0, 3};

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  obi_req_t  req_drv  [2];
  obi_resp_t resp_mon [2];
  logic      err_mon  [2];

  int compared   = 0;
  int mismatched = 0;

  // Model state: expected response of the transfer accepted last cycle and
  // per-byte memory contents (only bytes actually written are known).
  logic        pend     [2] = '{1'b0, 1'b0};
  int          stall    [2] = '{0, 0};
  logic [31:0] exp_data [2];
  logic [31:0] exp_mask [2];
  logic        exp_err  [2];
  logic [31:0] mdata  [int];
  logic [3:0]  mknown [int];

  always #5 clk = ~clk;

  obi_sram_resp #(.NUM_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req_drv[0]), .resp_o(resp_mon[0]), .err_o(err_mon[0]));

  obi_sram_resp #(.NUM_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req_drv[1]), .resp_o(resp_mon[1]), .err_o(err_mon[1]));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic req, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata);
    req_drv[d].req   = req;
    req_drv[d].we    = we;
    req_drv[d].addr  = addr;
    req_drv[d].be    = be;
    req_drv[d].wdata = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bbWord(input int i);
    return {8'hA5, 8'(i), 8'(i * 3), ~8'(i)};
  endfunction

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return BASE + 32'h1000 + 32'($urandom_range(0, 63));
      1:       return BASE - 32'd4;
      default: return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  // Transaction-level monitor: every cycle, both instances are compared with
  // what the model expects from grant timing and memory contents.
  always @(negedge clk) begin : monitor
    logic        eg;
    logic        inr;
    logic [31:0] off;
    logic [31:0] word;
    logic [3:0]  known;
    int          key;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        checkOutput($sformatf("rst_gnt%0d", d), 32'(resp_mon[d].gnt), 32'd0);
        checkOutput($sformatf("rst_rvalid%0d", d), 32'(resp_mon[d].rvalid), 32'd0);
        checkOutput($sformatf("rst_rdata%0d", d), resp_mon[d].rdata, 32'd0);
        checkOutput($sformatf("rst_err%0d", d), 32'(err_mon[d]), 32'd0);
        pend[d]  = 1'b0;
        stall[d] = 0;
      end else begin
        eg = req_drv[d].req && (stall[d] == WAITS[d]);
        checkOutput($sformatf("mon_gnt%0d", d), 32'(resp_mon[d].gnt), 32'(eg));
        checkOutput($sformatf("mon_rvalid%0d", d), 32'(resp_mon[d].rvalid), 32'(pend[d]));
        if (pend[d]) begin
          checkOutput($sformatf("mon_rdata%0d", d), resp_mon[d].rdata & exp_mask[d], exp_data[d] & exp_mask[d]);
          checkOutput($sformatf("mon_err%0d", d), 32'(err_mon[d]), 32'(exp_err[d]));
        end else begin
          checkOutput($sformatf("mon_idle_rdata%0d", d), resp_mon[d].rdata, 32'd0);
          checkOutput($sformatf("mon_idle_err%0d", d), 32'(err_mon[d]), 32'd0);
        end
        stall[d] = (req_drv[d].req && !eg) ? stall[d] + 1 : 0;
        pend[d]  = eg;
        if (eg) begin
          off = req_drv[d].addr - BASE;
          inr = (req_drv[d].addr >= BASE) && (off < 32'h1000);
          if (!inr) begin
            exp_data[d] = ERR_WORD;
            exp_mask[d] = '1;
            exp_err[d]  = 1'b1;
          end else begin
            key        = d * 65536 + int'(off >> 2);
            exp_err[d] = 1'b0;
            word       = mdata.exists(key) ? mdata[key] : 32'd0;
            known      = mknown.exists(key) ? mknown[key] : 4'd0;
            if (req_drv[d].we) begin
              for (int k = 0; k < 4; k++) begin
                if (req_drv[d].be[k]) begin
                  word[8*k +: 8] = req_drv[d].wdata[8*k +: 8];
                  known[k]       = 1'b1;
                end
              end
              mdata[key]  = word;
              mknown[key] = known;
              exp_data[d] = 32'd0;
              exp_mask[d] = '1;
            end else begin
              exp_data[d] = word;
              for (int k = 0; k < 4; k++) begin
                exp_mask[d][8*k +: 8] = known[k] ? 8'hFF : 8'h00;
              end
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b1, 32'hF0010004, 4'b1111, 32'h11223344, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 32'hF0010004, 4'b1111, 32'h00000000, 32'h11223344, 1'b0};
    vecs[2]  = '{1'b1, 32'hF0010004, 4'b0010, 32'hAABBCCDD, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 32'hF0010004, 4'b0000, 32'h00000000, 32'h1122CC44, 1'b0};
    vecs[4]  = '{1'b1, 32'hF0010004, 4'b0000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 32'hF0010006, 4'b1111, 32'h00000000, 32'h1122CC44, 1'b0};
    vecs[6]  = '{1'b1, 32'hF0010000, 4'b1111, 32'h0BAD0000, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 32'hF0011000, 4'b1111, 32'h00000000, 32'hBADCAB1E, 1'b1};
    vecs[8]  = '{1'b1, 32'hF0011000, 4'b1111, 32'hDEADBEEF, 32'hBADCAB1E, 1'b1};
    vecs[9]  = '{1'b0, 32'hF0010000, 4'b1111, 32'h00000000, 32'h0BAD0000, 1'b0};
    vecs[10] = '{1'b0, 32'hF000FFFC, 4'b1111, 32'h00000000, 32'hBADCAB1E, 1'b1};
    vecs[11] = '{1'b1, 32'hF0010FFC, 4'b1111, 32'h12345678, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 32'hF0010FFC, 4'b1111, 32'h00000000, 32'h12345678, 1'b0};

    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_rvalid", 32'(resp_mon[0].rvalid), 32'd0);
    checkOutput("reset_rdata", resp_mon[0].rdata, 32'd0);
    nextCycle();
    rst = 1'b0;

    // Single transfers on the zero-wait instance.
    foreach (vecs[i]) begin
      applyStimulus(0, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_gnt", i), 32'(resp_mon[0].gnt), 32'd1);
      nextCycle();
      applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rvalid", i), 32'(resp_mon[0].rvalid), 32'd1);
      checkOutput($sformatf("vec%0d_rdata", i), resp_mon[0].rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 32'(err_mon[0]), 32'(vecs[i].exp_err));
      nextCycle();
    end

    // Back-to-back writes then reads of words 0..7.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b1, 1'b1, BASE + 32'(4 * i), 4'b1111, bbWord(i));
      nextCycle();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b1, 1'b0, BASE + 32'(4 * i), 4'b1111, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_gnt", i), 32'(resp_mon[0].gnt), 32'd1);
      checkOutput($sformatf("b2b%0d_rvalid", i), 32'(resp_mon[0].rvalid), 32'd1);
      checkOutput($sformatf("b2b%0d_rdata", i), resp_mon[0].rdata, (i == 0) ? 32'd0 : bbWord(i - 1));
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b7_rdata", resp_mon[0].rdata, bbWord(7));
    nextCycle();
    @(negedge clk);
    checkOutput("b2b_end_rvalid", 32'(resp_mon[0].rvalid), 32'd0);
    nextCycle();

    // Read granted directly after a write to the same word.
    applyStimulus(0, 1'b1, 1'b1, BASE + 32'd36, 4'b1111, 32'h55AA55AA);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, BASE + 32'd36, 4'b1111, 32'd0);
    @(negedge clk);
    checkOutput("raw_wr_rdata", resp_mon[0].rdata, 32'd0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("raw_rd_rdata", resp_mon[0].rdata, 32'h55AA55AA);
    nextCycle();

    // Three-wait instance: write, held read, then an abandoned request.
    for (int t = 0; t < 2; t++) begin
      applyStimulus(1, 1'b1, (t == 0), BASE + 32'd8, 4'b1111, 32'hCAFEF00D);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        checkOutput($sformatf("w3_t%0d_c%0d_gnt", t, k), 32'(resp_mon[1].gnt), 32'(k == 4));
        nextCycle();
      end
      applyStimulus(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("w3_t%0d_rvalid", t), 32'(resp_mon[1].rvalid), 32'd1);
      checkOutput($sformatf("w3_t%0d_rdata", t), resp_mon[1].rdata, (t == 0) ? 32'd0 : 32'hCAFEF00D);
      nextCycle();
    end
    applyStimulus(1, 1'b1, 1'b0, BASE + 32'd8, 4'b1111, 32'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("w3_drop_c%0d_gnt", k), 32'(resp_mon[1].gnt), 32'd0);
      nextCycle();
    end
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, BASE + 32'd8, 4'b1111, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("w3_re_c%0d_gnt", k), 32'(resp_mon[1].gnt), 32'(k == 4));
      nextCycle();
    end
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("w3_re_rdata", resp_mon[1].rdata, 32'hCAFEF00D);
    nextCycle();

    // Reset pulsed between a read grant and its response.
    applyStimulus(0, 1'b1, 1'b0, BASE + 32'd12, 4'b1111, 32'd0);
    @(negedge clk);
    checkOutput("rstmid_gnt", 32'(resp_mon[0].gnt), 32'd1);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_gnt_masked", 32'(resp_mon[0].gnt), 32'd0);
    checkOutput("rstmid_rvalid", 32'(resp_mon[0].rvalid), 32'd0);
    checkOutput("rstmid_rdata", resp_mon[0].rdata, 32'd0);
    checkOutput("rstmid_err", 32'(err_mon[0]), 32'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstpost_gnt", 32'(resp_mon[0].gnt), 32'd1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("rstpost_rdata", resp_mon[0].rdata, bbWord(3));
    nextCycle();

    // Random traffic on both instances, checked by the monitor.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 7) < ((d == 0) ? 5 : 7)) begin
          applyStimulus(d, 1'b1, 1'($urandom_range(0, 1)), randAddr(), 4'($urandom), $urandom);
        end else begin
          applyStimulus(d, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        end
      end
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
